// File: rtl/seq_det_scan_ctrl.sv
// seq_det_scan_ctrl: word-to-serial scan controller counting sequence-detector hits per word (optional SEQ_SCAN_FIRSTPOS_EN)
module seq_det_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     abort,
  output logic                     det_x,
  output logic                     det_rst,
  input  logic                     det_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_hit,
`ifdef SEQ_SCAN_FIRSTPOS_EN
  output logic [$clog2(WIDTH)-1:0] out_first_pos,
`endif
  output logic                     out_sat
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DRAIN = 2'd2, REPORT = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d, run_q, hit;
`ifdef SEQ_SCAN_FIRSTPOS_EN
  logic [BW-1:0]    pos_q, pos_d;
`endif
  // det_y reports the bit sent in the previous cycle
  assign hit = det_y & ((state_q == SHIFT && bitcnt_q != '0) || state_q == DRAIN);
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = count_q;
    sat_d    = sat_q;
`ifdef SEQ_SCAN_FIRSTPOS_EN
    pos_d    = pos_q;
    if (hit && count_q == '0) pos_d = (state_q == DRAIN) ? BW'(WIDTH - 1) : bitcnt_q - 1'b1;
`endif
    if (hit) begin
      count_d = &count_q ? count_q : count_q + 1'b1;
      sat_d   = sat_q | &count_q;
    end
    if (state_q == IDLE) begin
      if (in_valid && run_q) begin
        state_d  = SHIFT;
        shreg_d  = in_data;
        bitcnt_d = '0;
        count_d  = '0;
        sat_d    = 1'b0;
`ifdef SEQ_SCAN_FIRSTPOS_EN
        pos_d    = '0;
`endif
      end
    end else if (abort && state_q != REPORT) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      shreg_d  = shreg_q << 1;
      bitcnt_d = bitcnt_q + 1'b1;
      state_d  = (bitcnt_q == BW'(WIDTH - 1)) ? DRAIN : SHIFT;
    end else if (state_q == DRAIN) begin
      state_d = REPORT;
    end else if (out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      run_q    <= 1'b0;
`ifdef SEQ_SCAN_FIRSTPOS_EN
      pos_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      run_q    <= 1'b1;
`ifdef SEQ_SCAN_FIRSTPOS_EN
      pos_q    <= pos_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE && run_q;
  assign det_rst   = state_q == IDLE || state_q == REPORT;
  assign det_x     = state_q == SHIFT && shreg_q[WIDTH-1];
  assign out_valid = state_q == REPORT;
  assign out_count = count_q;
  assign out_hit   = |count_q;
  assign out_sat   = sat_q;
`ifdef SEQ_SCAN_FIRSTPOS_EN
  assign out_first_pos = pos_q;
`endif
endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// tb_seq_det_scan_ctrl: directed and random words against a "1111" non-overlapping detector and a per-word hit model
module tb_seq_det_scan_ctrl;
  logic clk = 0, reset = 0, in_valid = 0, abort = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, det_x, det_rst, out_valid, out_hit, out_sat;
  logic in_ready2, det_x2, det_rst2, out_valid2, out_hit2, out_sat2;
  logic [4:0] out_count;
  logic [1:0] out_count2;
  logic det_y = 0, det_y2 = 0;
  int run1 = 0, run2 = 0, checks = 0, errors = 0;
`ifdef SEQ_SCAN_FIRSTPOS_EN
  logic [3:0] out_first_pos, out_first_pos2;
`endif
  always #5 clk = ~clk;
  seq_det_scan_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort), .det_x(det_x), .det_rst(det_rst), .det_y(det_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_hit(out_hit),
`ifdef SEQ_SCAN_FIRSTPOS_EN
    .out_first_pos(out_first_pos),
`endif
    .out_sat(out_sat));
  seq_det_scan_ctrl #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .abort(abort), .det_x(det_x2), .det_rst(det_rst2), .det_y(det_y2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_count(out_count2), .out_hit(out_hit2),
`ifdef SEQ_SCAN_FIRSTPOS_EN
    .out_first_pos(out_first_pos2),
`endif
    .out_sat(out_sat2));
  always @(posedge clk) begin
    if (det_rst || !det_x) begin run1 <= 0; det_y <= 0; end
    else if (run1 == 3) begin run1 <= 0; det_y <= 1; end
    else begin run1 <= run1 + 1; det_y <= 0; end
    if (det_rst2 || !det_x2) begin run2 <= 0; det_y2 <= 0; end
    else if (run2 == 3) begin run2 <= 0; det_y2 <= 1; end
    else begin run2 <= run2 + 1; det_y2 <= 0; end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void ref_word(input logic [15:0] w, input int maxc, output int cnt, output int sat, output int pos);
    int run, hits;
    run = 0; hits = 0; pos = 0;
    for (int i = 0; i < 16; i++) begin
      if (w[15-i]) begin
        run++;
        if (run == 4) begin hits++; run = 0; if (hits == 1) pos = i; end
      end else run = 0;
    end
    cnt = hits > maxc ? maxc : hits;
    sat = hits > maxc ? 1 : 0;
  endfunction
  task automatic run_word(input logic [15:0] w, input int hold);
    int n, c1, s1, p1, c2, s2, p2;
    ref_word(w, 31, c1, s1, p1);
    ref_word(w, 3, c2, s2, p2);
    in_valid = 1; in_data = w; n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("accept_ready", in_ready, 1);
    step();
    in_valid = 0; in_data = ~w;
    for (int i = 0; i < 16; i++) begin
      chk("det_x_bit", det_x, w[15-i]);
      chk("det_rst_shift", det_rst, 0);
      step();
    end
    chk("drain_x", det_x, 0);
    chk("drain_rst", det_rst, 0);
    chk("drain_no_valid", out_valid, 0);
    step();
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", out_valid, 1);
      chk("report_det_rst", det_rst, 1);
      chk("report_in_ready", in_ready, 0);
      chk("count", out_count, c1);
      chk("hit", out_hit, c1 != 0);
      chk("sat", out_sat, s1);
      chk("count_cw2", out_count2, c2);
      chk("hit_cw2", out_hit2, c2 != 0);
      chk("sat_cw2", out_sat2, s2);
`ifdef SEQ_SCAN_FIRSTPOS_EN
      chk("first_pos", out_first_pos, p1);
      chk("first_pos_cw2", out_first_pos2, p2);
`endif
      if (h == hold) out_ready = 1;
      else begin in_valid = 1; in_data = 16'hFFFF; end
      step();
      in_valid = 0;
    end
    out_ready = 0;
    chk("post_handshake_valid", out_valid, 0);
    chk("post_handshake_ready", in_ready, 1);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_det_rst", det_rst, 1);
    chk("rst_det_x", det_x, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_hit", out_hit, 0);
    chk("rst_sat", out_sat, 0);
`ifdef SEQ_SCAN_FIRSTPOS_EN
    chk("rst_first_pos", out_first_pos, 0);
`endif
    step(); step();
    reset = 1;
    step();
    chk("idle_in_ready", in_ready, 1);
    run_word(16'hF000, 0);
    run_word(16'hFFFF, 0);
    run_word(16'h0000, 0);
    run_word(16'h8000, 0);
    run_word(16'h0003, 0);
    run_word(16'hC000, 0);
    run_word(16'h7BDE, 5);
    in_valid = 1; in_data = 16'hFFFF;
    step();
    in_valid = 0;
    repeat (5) step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_idle", in_ready, 1);
    chk("abort_det_rst", det_rst, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin seen += out_valid; step(); end
      chk("abort_no_report", seen, 0);
    end
    in_valid = 1; in_data = 16'hFFFF;
    step();
    in_valid = 0;
    repeat (4) step();
    reset = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_det_rst", det_rst, 1);
    chk("mid_rst_det_x", det_x, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_hit", out_hit, 0);
    chk("mid_rst_sat", out_sat, 0);
    step();
    reset = 1;
    run_word(16'hF000, 0);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (k % 3 == 0) w = w | 16'($urandom) | 16'($urandom);
      run_word(w, int'($urandom_range(0, 3)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_det_scan_ctrl.md
# seq_det_scan_ctrl

Word-level scan controller for the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and clears the detector before each word. It then shifts the word MSB-first into the detector's `x` input, collects the detector's registered `y` flags, and returns a per-word hit count over a second valid/ready handshake. It sits between a parallel producer and one detector instance and owns that detector's `x` and `reset` pins.

## Interface
- `WIDTH`, 16: bits per word, ≥2.
- `CNT_W`, 5: width of the hit counter; the count saturates at 2^CNT_W−1.
- `clk`  in  1  rising-edge clock, shared with the detector.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  word available.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  WIDTH  word; bit WIDTH−1 is sent first.
- `abort`  in  1  synchronous; cancels the word in flight.
- `det_x`  out  1  serial bit to the detector `x`.
- `det_rst`  out  1  active-high synchronous clear to the detector `reset`.
- `det_y`  in  1  detector `y`, registered, one cycle after the completing bit.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_count`  out  CNT_W  hits in the word.
- `out_hit`  out  1  `out_count != 0`.
- `out_sat`  out  1  the counter saturated.
- `out_first_pos`  out  $clog2(WIDTH)  present only with the macro; see Configuration.

## Operation
- States: IDLE, SHIFT, DRAIN, REPORT. Reset enters IDLE.
- IDLE:
  - `in_ready`=1 and `det_rst`=1, so the detector is cleared every IDLE cycle.
  - On `in_valid & in_ready`: load the shift register, set `bitcnt`=0, clear the count, `sat` and first-pos, then go to SHIFT.
- SHIFT:
  - `det_rst`=0 and `det_x`=shreg[WIDTH−1].
  - Each cycle, shift left by one and increment `bitcnt`.
  - When `bitcnt`=WIDTH−1, go to DRAIN.
- DRAIN:
  - `det_x`=0, `det_rst`=0, one cycle.
  - This collects `y` for the last bit, then go to REPORT.
- Sampling:
  - `det_y` is sampled in SHIFT cycles with `bitcnt`≥1 and in the DRAIN cycle.
  - The sampled bit index is `bitcnt`−1, or WIDTH−1 in DRAIN.
  - Each sampled 1 increments the count. At the maximum the count holds and `sat` is set.
- REPORT:
  - `out_valid`=1, `det_rst`=1.
  - `out_count`, `out_hit` and `out_sat` are held stable until `out_valid & out_ready`, then go to IDLE.
- `abort`:
  - In SHIFT or DRAIN: go to IDLE next edge with no report. The result registers become don't-care.
  - In IDLE or REPORT: ignored.
- Async reset assertion mid-word: immediate return to IDLE and the word is dropped. `det_rst` is 1 while `reset`=0, so the detector is held cleared.

## Timing
- Reset values:
  - `in_ready`=0 while `reset`=0, then 1 in IDLE.
  - `det_rst`=1, `det_x`=0, `out_valid`=0.
  - `out_count`=0, `out_hit`=0, `out_sat`=0, `out_first_pos`=0.
- `in_ready`, `out_valid`, `det_x` and `det_rst` decode registered state only. There are no combinational input-to-output paths.
- Accept at edge t:
  - Bit i is driven in cycle t+i.
  - DRAIN is cycle t+WIDTH.
  - `out_valid` rises at edge t+WIDTH+1.
- Throughput:
  - Minimum word period is WIDTH+3 cycles, with `out_ready` tied high.
  - No new word is accepted until the result is taken.
- `out_valid` with `out_ready` low holds all result outputs indefinitely.

## Configuration
- Macro `SEQ_SCAN_FIRSTPOS_EN`.
- Defined:
  - Adds the `out_first_pos` port and register.
  - It latches the bit index (0 = first bit sent) of the first sampled `det_y`=1.
  - Valid only when `out_hit`=1, otherwise 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
All scenarios use WIDTH=16 and CNT_W=5 unless noted.
- Single hit: `in_data`=16'hF000 → `out_count`=1, `out_hit`=1, `out_sat`=0; `out_first_pos`=3 with the macro; `out_valid` rises 17 cycles after the accept edge.
- Repeated hits: 16'hFFFF → `out_count`=4, first_pos=3. 16'h0000 → count 0, `out_hit`=0. 16'h8000 → count 0.
- Clear between words: 16'h0003 then 16'hC000 → both counts are 0. A count of 1 on the second word means `det_rst` failed.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → result stable, `in_ready`=0, `in_valid` ignored. The next word is accepted only after the handshake.
- Abort and reset: pulse `abort` at the 6th SHIFT cycle → IDLE next edge, no `out_valid`. Drop `reset` mid-SHIFT → all outputs at reset values immediately, `det_rst`=1. Next word 16'hF000 → count 1.
- Saturation: CNT_W=2 with 16'hFFFF → `out_count`=3, `out_sat`=1, `out_hit`=1.
